// File: rtl/spike_aer_encoder.sv
// Spike capture, round-robin arbitration and AER event FIFO for one neuron row.
// Each spike is latched with the current timestep and drained as an {addr, ts} event over valid/ready.
module spike_aer_encoder #(
  parameter int unsigned N_NEURONS  = 7,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned TS_W       = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_NEURONS-1:0]          spike_in,
  input  logic                          ts_tick,
  input  logic                          ev_ready,
  input  logic                          clear_ovf,
  output logic                          ev_valid,
  output logic [ADDR_W-1:0]             ev_addr,
  output logic [TS_W-1:0]               ev_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned EntryW = ADDR_W + TS_W;
  localparam int unsigned DropW  = $clog2(N_NEURONS + 1);
  localparam logic [PtrW:0]       FullCount = FIFO_DEPTH[PtrW:0];
  localparam logic [ADDR_W-1:0]   LastIdx   = ADDR_W'(N_NEURONS - 1);

  logic [TS_W-1:0]      ts_q, ts_d;
  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [TS_W-1:0]      pending_ts_q [N_NEURONS];
  logic [TS_W-1:0]      pending_ts_d [N_NEURONS];
  logic [ADDR_W-1:0]    rr_q, rr_d;
  logic [EntryW-1:0]    mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [PtrW:0]        count_q, count_d;
  logic [EntryW-1:0]    head_q, head_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           drop_q, drop_d;

  logic                 pop, push_ok, gnt_found, grant;
  logic [ADDR_W-1:0]    gnt_idx, cand;
  logic [N_NEURONS-1:0] gnt_vec;
  logic [EntryW-1:0]    push_data;
  logic [DropW-1:0]     drops;
  logic [8:0]           drop_sum;

  assign ev_valid   = (count_q != '0);
  assign pop        = ev_valid & ev_ready;
  assign push_ok    = (count_q < FullCount) | pop;
  assign grant      = gnt_found & push_ok;
  assign gnt_vec    = grant ? (N_NEURONS'(1) << gnt_idx) : '0;
  assign push_data  = {gnt_idx, pending_ts_q[gnt_idx]};
  assign ev_addr    = head_q[EntryW-1:TS_W];
  assign ev_ts      = head_q[TS_W-1:0];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

  // First pending neuron at or after rr_q, wrapping modulo N_NEURONS.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned off = 0; off < N_NEURONS; off++) begin
      cand = ADDR_W'((32'(rr_q) + off) % N_NEURONS);
      if (!gnt_found && pending_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    pending_d    = pending_q & ~gnt_vec;
    pending_ts_d = pending_ts_q;
    drops        = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (spike_in[i]) begin
        if (!pending_q[i] || gnt_vec[i]) begin
          pending_d[i]    = 1'b1;
          pending_ts_d[i] = ts_q;
        end else begin
          drops += DropW'(1);
        end
      end
    end
    // A drop in the same cycle as clear_ovf is counted from zero.
    drop_sum   = {1'b0, (clear_ovf ? 8'd0 : drop_q)} + 9'(drops);
    drop_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    overflow_d = (drops != '0) | (overflow_q & ~clear_ovf);
    ts_d       = ts_tick ? ts_q + TS_W'(1) : ts_q;
    rr_d       = rr_q;
    if (grant) begin
      rr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + ADDR_W'(1);
    end
  end

  always_comb begin
    wr_d    = grant ? wr_q + PtrW'(1) : wr_q;
    rd_d    = pop ? rd_q + PtrW'(1) : rd_q;
    count_d = count_q;
    if (grant && !pop) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (!grant && pop) begin
      count_d = count_q - (PtrW+1)'(1);
    end
    // Registered show-ahead head; bypass the entry being written this cycle.
    head_d = head_q;
    if (count_d != '0) begin
      head_d = (grant && (wr_q == rd_d)) ? push_data : mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      mem_q[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q       <= '0;
      pending_q  <= '0;
      rr_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        pending_ts_q[i] <= '0;
      end
    end else begin
      ts_q         <= ts_d;
      pending_q    <= pending_d;
      pending_ts_q <= pending_ts_d;
      rr_q         <= rr_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      head_q       <= head_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
    end
  end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: an event-queue model checked every cycle,
// plus literal expectations for each scenario.
module tb_spike_aer_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] spike_in = '0;
  logic       ts_tick = 1'b0;
  logic       ev_ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       ev_valid;
  logic [2:0] ev_addr;
  logic [7:0] ev_ts;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [7:0] drop_count;

  spike_aer_encoder #(
    .N_NEURONS (7),
    .ADDR_W    (3),
    .TS_W      (8),
    .FIFO_DEPTH(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .spike_in  (spike_in),
    .ts_tick   (ts_tick),
    .ev_ready  (ev_ready),
    .clear_ovf (clear_ovf),
    .ev_valid  (ev_valid),
    .ev_addr   (ev_addr),
    .ev_ts     (ev_ts),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {int a; int t;} ev_t;

  int  vectors = 0;
  int  miscompares = 0;

  // Model state: queued events, pending flags with stamps, pointer, counters.
  ev_t q[$];
  ev_t got[$];
  bit  pend[7];
  int  pts[7];
  int  rr, m_ts, dcnt;
  bit  ovf;
  bit  model_ok = 1'b0;
  bit  head_valid = 1'b0;
  ev_t head;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int g;
    int nd;
    bit pop_m;
    if (reset) begin
      q.delete();
      got.delete();
      for (int i = 0; i < 7; i++) begin
        pend[i] = 1'b0;
        pts[i]  = 0;
      end
      rr = 0; m_ts = 0; dcnt = 0; ovf = 1'b0;
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    pop_m = (q.size() > 0) && ev_ready;
    g = -1;
    if (q.size() < 8 || pop_m) begin
      for (int off = 0; off < 7; off++) begin
        if (g < 0 && pend[(rr + off) % 7]) g = (rr + off) % 7;
      end
    end
    if (pop_m) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back('{g, pts[g]});
      pend[g] = 1'b0;
      rr = (g + 1) % 7;
    end
    nd = 0;
    for (int i = 0; i < 7; i++) begin
      if (spike_in[i]) begin
        if (pend[i]) nd++;
        else begin
          pend[i] = 1'b1;
          pts[i]  = m_ts;
        end
      end
    end
    if (clear_ovf) begin
      ovf = 1'b0;
      dcnt = 0;
    end
    if (nd > 0) begin
      ovf = 1'b1;
      dcnt = (dcnt + nd > 255) ? 255 : dcnt + nd;
    end
    m_ts = (m_ts + int'(ts_tick)) % 256;
  endtask

  // Single checker: advance the model at each edge, compare DUT 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      if (model_ok && head_valid && ev_ready && !reset) got.push_back(head);
      model_step();
      #1;
      if (model_ok) begin
        cmp("ev_valid", ev_valid, (q.size() != 0));
        cmp("fifo_count", fifo_count, q.size());
        if (q.size() != 0) begin
          cmp("ev_addr", ev_addr, q[0].a);
          cmp("ev_ts", ev_ts, q[0].t);
        end
        cmp("overflow", overflow, ovf);
        cmp("drop_count", drop_count, dcnt);
      end
      head_valid = model_ok && ev_valid;
      head = '{int'(ev_addr), int'(ev_ts)};
    end
  end

  task automatic cyc(input logic [6:0] sp, input logic tk, input logic rdy,
                     input logic clr, input logic rst);
    spike_in  = sp;
    ts_tick   = tk;
    ev_ready  = rdy;
    clear_ovf = clr;
    reset     = rst;
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) cyc(7'b0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(7'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(7'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Single spike: valid exactly one cycle, two edges after the spike.
    do_reset();
    cmp("rst_valid", ev_valid, 0);
    cmp("rst_addr", ev_addr, 0);
    cmp("rst_ts", ev_ts, 0);
    cmp("rst_count", fifo_count, 0);
    cmp("rst_ovf", overflow, 0);
    cmp("rst_drops", drop_count, 0);
    cyc(7'b0000100, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("s1_not_yet", ev_valid, 0);
    cyc(7'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("s1_valid", ev_valid, 1);
    cmp("s1_addr", ev_addr, 2);
    cmp("s1_ts", ev_ts, 0);
    cyc(7'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("s1_gone", ev_valid, 0);
    cmp("s1_count", fifo_count, 0);
    idle(3, 1'b1);
    cmp("s1_nev", got.size(), 1);

    // All seven at once, then round-robin resumes at 0.
    do_reset();
    cyc(7'b1111111, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(10, 1'b1);
    cmp("s2_nev", got.size(), 7);
    for (int i = 0; i < 7 && i < got.size(); i++) cmp("s2_order", got[i].a, i);
    cyc(7'b1000001, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    cmp("s2_nev2", got.size(), 9);
    if (got.size() >= 9) begin
      cmp("s2_rr0", got[7].a, 0);
      cmp("s2_rr6", got[8].a, 6);
    end

    // Fill FIFO, accumulate pending, then drops and clear_ovf interaction.
    do_reset();
    cyc(7'b1111111, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8, 1'b0);
    cmp("s3_count7", fifo_count, 7);
    cyc(7'b1111111, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    cmp("s3_full", fifo_count, 8);
    cmp("s3_no_ovf", overflow, 0);
    cmp("s3_no_drop", drop_count, 0);
    cyc(7'b0000010, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("s3_ovf", overflow, 1);
    cmp("s3_drop1", drop_count, 1);
    cyc(7'b0000010, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("s3_clr_drop_ovf", overflow, 1);
    cmp("s3_clr_drop_cnt", drop_count, 1);
    cyc(7'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("s3_clr_ovf", overflow, 0);
    cmp("s3_clr_cnt", drop_count, 0);
    cyc(7'b1111110, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("s3_multi_drop", drop_count, 6);

    // Full FIFO with pending neuron 5: simultaneous pop and push.
    do_reset();
    cyc(7'b1111111, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8, 1'b0);
    cyc(7'b0100000, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    cmp("s5_full", fifo_count, 8);
    cyc(7'b0100000, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    cmp("s5_still_full", fifo_count, 8);
    cyc(7'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("s5_pushpop", fifo_count, 8);
    idle(12, 1'b1);
    cmp("s5_nev", got.size(), 9);
    if (got.size() == 9) cmp("s5_last", got[8].a, 5);
    cmp("s5_drained", fifo_count, 0);

    // Timestep wrap: stamped 255 on the 256th tick, next spike stamped 0.
    do_reset();
    repeat (255) cyc(7'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(7'b0001000, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    cyc(7'b0001000, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    cmp("s4_nev", got.size(), 2);
    if (got.size() == 2) begin
      cmp("s4_addr", got[0].a, 3);
      cmp("s4_ts255", got[0].t, 255);
      cmp("s4_ts0", got[1].t, 0);
    end

    // Reset mid-operation discards queued and pending events.
    do_reset();
    cyc(7'b0011111, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);
    cyc(7'b0000011, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("s6_count5", fifo_count, 5);
    cyc(7'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("s6_valid", ev_valid, 0);
    cmp("s6_count", fifo_count, 0);
    cmp("s6_addr_rst", ev_addr, 0);
    cyc(7'b0000001, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    cmp("s6_nev", got.size(), 1);
    if (got.size() == 1) begin
      cmp("s6_ev_addr", got[0].a, 0);
      cmp("s6_ev_ts", got[0].t, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spike_aer_encoder.md
Name: spike_aer_encoder

Overview:
- Downstream stage of the systolic MAC/LIF neuron row.
- Captures the per-neuron spike pulses and latches each with the current timestep.
- Picks pending spikes one per cycle with a round-robin arbiter and queues them as address-event (AER) words in a small FIFO.
- Drains the FIFO over a valid/ready interface to the off-chip output path. Tracks lost spikes.

Parameters:
- N_NEURONS, 7, number of spike inputs (LIF instances in the row).
- ADDR_W, 3, event address width; must satisfy 2^ADDR_W >= N_NEURONS.
- TS_W, 8, timestep counter/stamp width.
- FIFO_DEPTH, 8, event FIFO entries; power of two.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- spike_in  in  N_NEURONS  one-cycle spike pulses; bit i from neuron i.
- ts_tick  in  1  advance timestep counter.
- ev_ready  in  1  consumer accepts the head event.
- clear_ovf  in  1  clears overflow and drop_count.
- ev_valid  out  1  FIFO non-empty.
- ev_addr  out  ADDR_W  neuron index of head event.
- ev_ts  out  TS_W  timestep stamp of head event.
- fifo_count  out  log2(FIFO_DEPTH)+1  occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky: a spike was dropped.
- drop_count  out  8  dropped spikes, saturating at 255.

Behaviour:
- Reset (synchronous, active-high, dominates every other input):
  - timestep, pending[], pending_ts[], rr_ptr, FIFO pointers and count, overflow, drop_count all go to 0.
  - Outputs after reset: ev_valid=0, ev_addr=0, ev_ts=0, fifo_count=0, overflow=0, drop_count=0.
  - Reset mid-operation discards all queued and pending events.
- Timestep counter:
  - Increments on ts_tick and wraps at 2^TS_W-1 -> 0.
  - A spike arriving in the same cycle as ts_tick is stamped with the pre-increment value.
- Capture, per neuron i, on each edge:
  - If spike_in[i]=1 and pending[i]=0, or pending[i]=1 and i is granted this cycle: set pending[i]=1 and pending_ts[i]=timestep.
  - If spike_in[i]=1, pending[i]=1 and i is not granted: the spike is dropped. pending_ts[i] keeps the older stamp, overflow is set to 1, and drop_count increments (saturating at 255).
  - If several neurons drop in the same cycle, drop_count adds the number dropped, still saturating.
- Arbiter:
  - Combinational. It searches pending[] starting at rr_ptr, wrapping modulo N_NEURONS, and grants the first set bit.
  - A grant happens only if push is allowed: fifo_count < FIFO_DEPTH, or fifo_count == FIFO_DEPTH with a pop in the same cycle.
  - On a grant: push {idx, pending_ts[idx]}, clear pending[idx] (unless re-set by that cycle's spike_in), and set rr_ptr = (idx+1) mod N_NEURONS.
  - With no grant, rr_ptr holds.
  - At most one push per cycle.
- FIFO:
  - Show-ahead; ev_addr and ev_ts are the head entry, registered.
  - Pop occurs when ev_valid & ev_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - When empty, ev_addr and ev_ts hold their last value; they are don't-care while ev_valid=0.
  - While full, pending bits accumulate and nothing is lost until a second spike hits an already-pending neuron.
- Latency:
  - Spike on spike_in at edge k -> pending at k -> pushed at edge k+1 -> ev_valid=1 after edge k+1 (empty FIFO, no contention).
  - Sustained throughput is 1 event/cycle.
- clear_ovf:
  - Zeros overflow and drop_count on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- Handshake:
  - ev_valid never deasserts without a pop.
  - ev_addr and ev_ts are stable while ev_valid=1 and ev_ready=0.

Test Plan:
- Reset then single spike_in=7'b0000100 at timestep 0, ev_ready=1 -> ev_valid for exactly one cycle with ev_addr=2 and ev_ts=0, two edges after the spike; fifo_count returns to 0.
- spike_in=7'b1111111 in one cycle, ev_ready=1, rr_ptr=0 -> seven events over consecutive cycles with addresses 0,1,2,3,4,5,6; a following spike_in=7'b0000001 plus 7'b1000000 -> grant order resumes at 0, then 6.
- ev_ready=0, spike all 7 neurons twice (non-consecutive cycles, 7 then 7 more) -> FIFO fills to 8 and 6 remain pending. Expected result: no drops (overflow=0). Then a third spike on a pending neuron -> overflow=1, drop_count=1.
- ts_tick asserted 255 times then a spike on neuron 3 coincident with the 256th tick -> ev_ts=255 for that event; the next spike is stamped 0 (wrap).
- FIFO full (count=8) with ev_ready=1 and pending neuron 5 -> pop and push in the same cycle; fifo_count stays 8; ev_addr of the final entry is 5.
- Assert reset while fifo_count=5 with pending bits set -> next cycle ev_valid=0 and fifo_count=0; a subsequent spike on neuron 0 emits ev_addr=0, ev_ts=0.
